avb_sample_ring_writer: RTL and testbench
=========================================

Name: avb_sample_ring_writer

Overview:
Avalon-ST-to-Avalon-MM write stage that sits directly upstream of the 2048x32 single-port on-chip sample RAM. It accepts 24-bit PCM samples from the AVB audio receive path and sign-extends each one to 32 bits. It writes them into the RAM as a circular buffer. It tracks fill level against a CPU-owned read pointer and raises an interrupt and a sticky overflow flag for the Nios driver.

Parameters:
ADDR_W, 11, RAM word-address width; DEPTH = 2**ADDR_W
SAMPLE_W, 24, input PCM sample width, signed
THRESH_DEFAULT, 1024, reset value of irq threshold register

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
enable  in  1  CPU control: 1 = accept samples
flush  in  1  CPU control, single-cycle pulse: clear pointers
ovf_clear  in  1  single-cycle pulse: clear sticky overflow, leave OVERFLOW state
rd_ptr  in  ADDR_W+1  CPU read pointer, extra MSB is wrap bit
thresh  in  ADDR_W+1  irq level threshold, loaded into internal register on thresh_load
thresh_load  in  1  single-cycle pulse: latch thresh
snk_valid  in  1  Avalon-ST sample valid
snk_data  in  SAMPLE_W  signed PCM sample
snk_ready  out  1  Avalon-ST ready, readyLatency 0
m_address  out  ADDR_W  RAM word address
m_chipselect  out  1  RAM chipselect
m_write  out  1  RAM write strobe
m_byteenable  out  4  always 4'b1111 when writing, else 0
m_writedata  out  32  sign-extended sample
wr_ptr  out  ADDR_W+1  write pointer, wrap bit in MSB
level  out  ADDR_W+1  wr_ptr - rd_ptr, modulo 2**(ADDR_W+1), range 0..DEPTH
overflow  out  1  sticky overflow flag
irq  out  1  level-sensitive interrupt

Behaviour:
- Reset (reset_n low, asynchronous) clears the following: state=DISABLED, wr_ptr=0, all m_* outputs 0, overflow=0, irq=0, snk_ready=0, threshold register=THRESH_DEFAULT.
- States:
  - DISABLED: snk_ready=0.
    - enable=1 -> RUNNING.
    - flush -> wr_ptr=0; flush is honoured only in this state.
  - RUNNING: snk_ready = (level < DEPTH).
    - enable=0 -> DISABLED.
    - snk_valid=1 while level==DEPTH -> OVERFLOW, overflow<=1, and the sample is dropped.
  - OVERFLOW: snk_ready=1; every sample is discarded with no RAM write.
    - ovf_clear -> overflow<=0; next state is RUNNING if enable=1, else DISABLED.
    - enable=0 also -> DISABLED, but overflow stays set.
- Accept = snk_valid & snk_ready in RUNNING.
  - On accept: wr_ptr increments with natural wrap 2**(ADDR_W+1)-1 -> 0.
  - Cycle N+1 after accept: m_chipselect=m_write=1, m_byteenable=4'hF, m_address=old wr_ptr[ADDR_W-1:0], m_writedata={{(32-SAMPLE_W){snk_data[SAMPLE_W-1]}}, snk_data}.
  - Write latency is one registered cycle. The RAM has no waitrequest, so each write completes in that cycle.
  - Back-to-back accepts produce back-to-back writes.
- level is combinational: wr_ptr - rd_ptr, truncated to ADDR_W+1 bits.
  - rd_ptr is trusted; a rd_ptr ahead of wr_ptr is a software error and gives an undefined level.
- irq = (level >= threshold_reg) | overflow, registered (one cycle after the condition).
- Simultaneous events:
  - Accept and rd_ptr update in the same cycle: both take effect, and level reflects both next cycle.
  - flush and enable in the same cycle in DISABLED: flush applies, and the state moves to RUNNING with wr_ptr=0.
  - ovf_clear while not in OVERFLOW clears the flag only.
- The final accepted sample is always written. After enable drops, the single in-flight write still completes on the next cycle.
- Reset asserted mid-write aborts the write: m_write drops immediately (async).

Test Plan:
- Reset, enable=1, rd_ptr=0, send samples 24'h000001, 24'h800000 -> writes at addr 0 data 32'h00000001, addr 1 data 32'hFF800000, each one cycle after accept; wr_ptr=2, level=2.
- Stream 2048 samples with rd_ptr=0 -> level=2048, snk_ready=0. An extra snk_valid gives state OVERFLOW, overflow=1, irq=1, and no RAM write.
- From full, set rd_ptr=12'h800 then pulse ovf_clear -> level=0, overflow=0, snk_ready=1. The next sample writes addr 0 and wr_ptr=12'h801, confirming wrap.
- Load thresh=4 and send 4 samples with rd_ptr=0 -> irq rises the cycle after level reaches 4. Set rd_ptr=1 -> irq falls one cycle later.
- Disable mid-stream, pulse flush -> wr_ptr=0, no writes while DISABLED. A flush pulse while RUNNING is ignored.
- Assert reset_n low during an active m_write -> all outputs 0 immediately, wr_ptr=0, state DISABLED.

Source files
------------

// File: rtl/avb_sample_ring_writer.sv
// Avalon-ST to Avalon-MM write stage: sign-extends 24-bit PCM samples into a
// 2**ADDR_W-word circular RAM buffer, tracking fill level, overflow and irq.
module avb_sample_ring_writer #(
  parameter int ADDR_W         = 11,
  parameter int SAMPLE_W       = 24,
  parameter int THRESH_DEFAULT = 1024
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                flush,
  input  logic                ovf_clear,
  input  logic [ADDR_W:0]     rd_ptr,
  input  logic [ADDR_W:0]     thresh,
  input  logic                thresh_load,
  input  logic                snk_valid,
  input  logic [SAMPLE_W-1:0] snk_data,
  output logic                snk_ready,
  output logic [ADDR_W-1:0]   m_address,
  output logic                m_chipselect,
  output logic                m_write,
  output logic [3:0]          m_byteenable,
  output logic [31:0]         m_writedata,
  output logic [ADDR_W:0]     wr_ptr,
  output logic [ADDR_W:0]     level,
  output logic                overflow,
  output logic                irq
);

  localparam int PW = ADDR_W + 1;
  localparam logic [PW-1:0] DEPTH_V  = PW'(2 ** ADDR_W);
  localparam logic [PW-1:0] THRESH_V = PW'(THRESH_DEFAULT);

  typedef enum logic [1:0] {
    S_DISABLED,
    S_RUNNING,
    S_OVERFLOW
  } state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     thresh_q, thresh_d;
  logic              overflow_q, overflow_d;
  logic              irq_q, irq_d;
  logic              m_write_q, m_write_d;
  logic [ADDR_W-1:0] m_address_q, m_address_d;
  logic [31:0]       m_writedata_q, m_writedata_d;

  logic [PW-1:0]     level_w;
  logic              full_w;
  logic              accept_w;

  // A software rd_ptr ahead of wr_ptr yields a level above DEPTH; treat that as full.
  assign level_w  = wr_ptr_q - rd_ptr;
  assign full_w   = (level_w >= DEPTH_V);
  assign snk_ready = (state_q == S_RUNNING) ? !full_w : (state_q == S_OVERFLOW);
  assign accept_w = snk_valid && snk_ready && (state_q == S_RUNNING);

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    overflow_d    = overflow_q;
    thresh_d      = thresh_load ? thresh : thresh_q;
    irq_d         = (level_w >= thresh_q) || overflow_q;
    m_write_d     = accept_w;
    m_address_d   = accept_w ? wr_ptr_q[ADDR_W-1:0] : '0;
    m_writedata_d = accept_w ? {{(32-SAMPLE_W){snk_data[SAMPLE_W-1]}}, snk_data} : '0;

    if (ovf_clear) begin
      overflow_d = 1'b0;
    end

    // An accept in the cycle enable drops still counts; its write completes next cycle.
    if (accept_w) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end

    case (state_q)
      S_DISABLED: begin
        if (flush) begin
          wr_ptr_d = '0;
        end
        if (enable) begin
          state_d = S_RUNNING;
        end
      end
      S_RUNNING: begin
        if (!enable) begin
          state_d = S_DISABLED;
        end else if (snk_valid && full_w) begin
          state_d    = S_OVERFLOW;
          overflow_d = 1'b1;
        end
      end
      S_OVERFLOW: begin
        if (ovf_clear) begin
          state_d = enable ? S_RUNNING : S_DISABLED;
        end else if (!enable) begin
          state_d = S_DISABLED;
        end
      end
      default: begin
        state_d = S_DISABLED;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_DISABLED;
      wr_ptr_q      <= '0;
      thresh_q      <= THRESH_V;
      overflow_q    <= 1'b0;
      irq_q         <= 1'b0;
      m_write_q     <= 1'b0;
      m_address_q   <= '0;
      m_writedata_q <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      thresh_q      <= thresh_d;
      overflow_q    <= overflow_d;
      irq_q         <= irq_d;
      m_write_q     <= m_write_d;
      m_address_q   <= m_address_d;
      m_writedata_q <= m_writedata_d;
    end
  end

  assign m_address    = m_address_q;
  assign m_chipselect = m_write_q;
  assign m_write      = m_write_q;
  assign m_byteenable = {4{m_write_q}};
  assign m_writedata  = m_writedata_q;
  assign wr_ptr       = wr_ptr_q;
  assign level        = level_w;
  assign overflow     = overflow_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_avb_sample_ring_writer.sv
// Scoreboard bench for avb_sample_ring_writer: expected RAM writes are queued
// at issue time and popped by an independent write monitor.
module tb_avb_sample_ring_writer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        flush;
  logic        ovf_clear;
  logic [11:0] rd_ptr;
  logic [11:0] thresh;
  logic        thresh_load;
  logic        snk_valid;
  logic [23:0] snk_data;
  logic        snk_ready;
  logic [10:0] m_address;
  logic        m_chipselect;
  logic        m_write;
  logic [3:0]  m_byteenable;
  logic [31:0] m_writedata;
  logic [11:0] wr_ptr;
  logic [11:0] level;
  logic        overflow;
  logic        irq;

  typedef struct packed {
    logic [10:0] addr;
    logic [31:0] data;
    logic [31:0] cyc;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] cyc = 0;
  logic [11:0] exp_ptr = 0;

  avb_sample_ring_writer dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .flush(flush),
    .ovf_clear(ovf_clear), .rd_ptr(rd_ptr), .thresh(thresh),
    .thresh_load(thresh_load), .snk_valid(snk_valid), .snk_data(snk_data),
    .snk_ready(snk_ready), .m_address(m_address), .m_chipselect(m_chipselect),
    .m_write(m_write), .m_byteenable(m_byteenable), .m_writedata(m_writedata),
    .wr_ptr(wr_ptr), .level(level), .overflow(overflow), .irq(irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] pat(input int i);
    pat = 24'(i * 40503) ^ 24'h9C0000;
  endfunction

  // Drives one sample in the current negedge slot; a queued write is expected
  // on the cycle right after the upcoming posedge.
  task automatic drive(input logic [23:0] d, input logic [31:0] exp_data,
                       input bit exp_rdy, input bit exp_wr_en);
    snk_valid = 1'b1;
    snk_data  = d;
    #1;
    check("snk_ready", {31'd0, snk_ready}, {31'd0, exp_rdy});
    if (exp_wr_en) begin
      sb.push_back(exp_t'{addr: exp_ptr[10:0], data: exp_data, cyc: cyc + 1});
      exp_ptr++;
    end
  endtask

  task automatic send(input logic [23:0] d, input logic [31:0] exp_data,
                      input bit exp_rdy, input bit exp_wr_en);
    @(negedge clk);
    drive(d, exp_data, exp_rdy, exp_wr_en);
  endtask

  task automatic idle();
    @(negedge clk);
    snk_valid = 1'b0;
    #1;
  endtask

  // Write monitor: every RAM write must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (m_write) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_write: actual addr=%h data=%h required no write", m_address, m_writedata);
        end else begin
          e = sb.pop_front();
          check("wr_addr", {21'd0, m_address}, {21'd0, e.addr});
          check("wr_data", m_writedata, e.data);
          check("wr_cycle", cyc, e.cyc);
          check("wr_cs", {31'd0, m_chipselect}, 32'd1);
          check("wr_be", {28'd0, m_byteenable}, 32'hF);
        end
      end
    end
  end

  initial begin
    logic [23:0] d;
    reset_n = 1'b0; enable = 1'b0; flush = 1'b0; ovf_clear = 1'b0;
    rd_ptr = '0; thresh = '0; thresh_load = 1'b0; snk_valid = 1'b0; snk_data = '0;

    repeat (3) @(negedge clk);
    #1;
    check("rst_ready", {31'd0, snk_ready}, 0);
    check("rst_write", {31'd0, m_write}, 0);
    check("rst_cs", {31'd0, m_chipselect}, 0);
    check("rst_be", {28'd0, m_byteenable}, 0);
    check("rst_addr", {21'd0, m_address}, 0);
    check("rst_data", m_writedata, 0);
    check("rst_wr_ptr", {20'd0, wr_ptr}, 0);
    check("rst_level", {20'd0, level}, 0);
    check("rst_overflow", {31'd0, overflow}, 0);
    check("rst_irq", {31'd0, irq}, 0);
    @(negedge clk) reset_n = 1'b1;

    // Two basic samples: sign extension of positive and most-negative values.
    @(negedge clk) enable = 1'b1;
    send(24'h000001, 32'h00000001, 1'b1, 1'b1);
    send(24'h800000, 32'hFF800000, 1'b1, 1'b1);
    idle();
    check("basic_wr_ptr", {20'd0, wr_ptr}, 2);
    check("basic_level", {20'd0, level}, 2);
    check("basic_irq", {31'd0, irq}, 0);

    // Fill the ring completely, then overflow it.
    for (int i = 0; i < 2046; i++) begin
      d = pat(i);
      send(d, {{8{d[23]}}, d}, 1'b1, 1'b1);
    end
    idle();
    check("full_level", {20'd0, level}, 2048);
    check("full_ready", {31'd0, snk_ready}, 0);
    check("full_wr_ptr", {20'd0, wr_ptr}, 12'h800);
    check("full_irq", {31'd0, irq}, 1);
    send(24'h00ABCD, 32'h0, 1'b0, 1'b0);
    idle();
    check("ovf_flag", {31'd0, overflow}, 1);
    check("ovf_ready", {31'd0, snk_ready}, 1);
    check("ovf_irq", {31'd0, irq}, 1);
    send(24'h7FFFFF, 32'h0, 1'b1, 1'b0);
    idle();
    check("ovf_wr_ptr", {20'd0, wr_ptr}, 12'h800);

    // Drain via rd_ptr, clear overflow, confirm wrap of the write address.
    @(negedge clk);
    rd_ptr = 12'h800;
    ovf_clear = 1'b1;
    @(negedge clk);
    ovf_clear = 1'b0;
    #1;
    check("clr_level", {20'd0, level}, 0);
    check("clr_overflow", {31'd0, overflow}, 0);
    check("clr_ready", {31'd0, snk_ready}, 1);
    send(24'hFFFFFE, 32'hFFFFFFFE, 1'b1, 1'b1);
    idle();
    check("wrap_wr_ptr", {20'd0, wr_ptr}, 12'h801);
    check("wrap_irq", {31'd0, irq}, 0);

    // Disable mid-stream: the last accepted sample is still written.
    send(24'h0A0A0A, 32'h000A0A0A, 1'b1, 1'b1);
    @(negedge clk);
    enable = 1'b0;
    drive(24'hF0F0F0, 32'hFFF0F0F0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) send(24'h111111, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    snk_valid = 1'b0;
    flush = 1'b1;
    rd_ptr = 12'h000;
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_wr_ptr", {20'd0, wr_ptr}, 0);
    check("flush_level", {20'd0, level}, 0);
    exp_ptr = 12'h000;

    // Flush while running must be ignored.
    @(negedge clk) enable = 1'b1;
    send(24'h123456, 32'h00123456, 1'b1, 1'b1);
    @(negedge clk);
    snk_valid = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("run_flush_wr_ptr", {20'd0, wr_ptr}, 1);

    // Threshold irq: rises one cycle after level hits 4, falls one cycle after it drops.
    @(negedge clk);
    thresh = 12'd4;
    thresh_load = 1'b1;
    @(negedge clk);
    thresh_load = 1'b0;
    #1;
    check("thr_irq_low", {31'd0, irq}, 0);
    send(24'h000010, 32'h00000010, 1'b1, 1'b1);
    send(24'hFFFFF0, 32'hFFFFFFF0, 1'b1, 1'b1);
    send(24'h7FFFFF, 32'h007FFFFF, 1'b1, 1'b1);
    idle();
    check("thr_level", {20'd0, level}, 4);
    check("thr_irq_lag", {31'd0, irq}, 0);
    idle();
    check("thr_irq_high", {31'd0, irq}, 1);
    @(negedge clk);
    rd_ptr = 12'd1;
    #1;
    check("thr_level_dn", {20'd0, level}, 3);
    check("thr_irq_hold", {31'd0, irq}, 1);
    idle();
    check("thr_irq_fall", {31'd0, irq}, 0);

    // Async reset during an active write.
    send(24'h400000, 32'h00400000, 1'b1, 1'b1);
    @(posedge clk);
    #2;
    check("pre_rst_write", {31'd0, m_write}, 1);
    reset_n = 1'b0;
    snk_valid = 1'b0;
    #1;
    check("arst_write", {31'd0, m_write}, 0);
    check("arst_cs", {31'd0, m_chipselect}, 0);
    check("arst_be", {28'd0, m_byteenable}, 0);
    check("arst_addr", {21'd0, m_address}, 0);
    check("arst_data", m_writedata, 0);
    check("arst_wr_ptr", {20'd0, wr_ptr}, 0);
    check("arst_ready", {31'd0, snk_ready}, 0);
    check("arst_irq", {31'd0, irq}, 0);
    repeat (2) @(negedge clk);
    #1;
    check("arst_hold_ready", {31'd0, snk_ready}, 0);
    check("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
